// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller and its datapaths.
package pong_pkg;

    // Match sequencing states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_t;

    localparam int SCORE_W = 4;

    // Launch directions, shared with the ball block.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Increment a score, sticking at the maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_tick_divider.sv
// Frame tick generator: divides clk by TICK_DIV, freezing its phase while held.
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    // A divide-by-one still needs a one-bit counter to keep the code uniform.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Phase counter: wraps at LAST, keeps its value while hold is high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of statement order.
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // A held divider produces no tick, so a paused frame never advances anything.
    assign tick = !hold && (count == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: frame enable, serve timing, scoring and game-over detection.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int SERVE_DELAY = 2,
    parameter int WIN_SCORE   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               en,
    output logic               serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam logic [7:0]         DELAY_LOAD = 8'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        state_q, state_d;
    logic [7:0]         delay_q, delay_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               dir_q, dir_d;
    logic               winner_q, winner_d;
    logic               serve_q, serve_d;
    logic               en_q;
    logic               game_over_q;
    logic               tick;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk (clk),
        .rst (rst),
        .hold(pause),
        .tick(tick)
    );

    // Next-state, scoring and serve-delay decisions for the match FSM.
    always_comb begin
        // NOTE: every variable gets a hold/default value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        delay_d  = delay_q;
        score1_d = score1_q;
        score2_d = score2_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        serve_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE_WAIT;
                    delay_d = DELAY_LOAD;
                    dir_d   = DIR_LEFT;
                end
            end

            SERVE_WAIT: begin
                // Count down in frame ticks; the last tick launches the ball.
                if (tick) begin
                    delay_d = delay_q - 1'b1;
                    if (delay_q <= 8'd1) begin
                        delay_d = '0;
                        state_d = PLAY;
                        serve_d = 1'b1;
                    end
                end
            end

            PLAY: begin
                // Misses are live every cycle, paused or not.
                if (miss_left && !miss_right) begin
                    score2_d = sat_inc(score2_q);
                    dir_d    = DIR_LEFT;
                    state_d  = POINT;
                end else if (miss_right && !miss_left) begin
                    score1_d = sat_inc(score1_q);
                    dir_d    = DIR_RIGHT;
                    state_d  = POINT;
                end else if (miss_left && miss_right) begin
                    // Double miss is a replayed point: nobody scores.
                    state_d = POINT;
                end
            end

            POINT: begin
                // Scores were updated on entry, so they can be judged here directly.
                if (score1_q == WIN_VAL) begin
                    state_d  = GAME_OVER;
                    winner_d = 1'b0;
                end else if (score2_q == WIN_VAL) begin
                    state_d  = GAME_OVER;
                    winner_d = 1'b1;
                end else begin
                    state_d = SERVE_WAIT;
                    delay_d = DELAY_LOAD;
                end
            end

            GAME_OVER: begin
                if (start) begin
                    score1_d = '0;
                    score2_d = '0;
                    dir_d    = DIR_LEFT;
                    delay_d  = DELAY_LOAD;
                    state_d  = SERVE_WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register the FSM and every output so downstream blocks see glitch-free levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            delay_q     <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            dir_q       <= DIR_LEFT;
            winner_q    <= 1'b0;
            serve_q     <= 1'b0;
            en_q        <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            dir_q       <= dir_d;
            winner_q    <= winner_d;
            serve_q     <= serve_d;
            en_q        <= tick && (state_q == PLAY) && !pause;
            game_over_q <= (state_d == GAME_OVER);
        end
    end

    assign en        = en_q;
    assign serve     = serve_q;
    assign serve_dir = dir_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed match scenarios plus random play,
// all compared each cycle against a behavioural match model.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int SERVE_DELAY = 2;
    localparam int WIN_SCORE   = 3;

    logic       clk = 1'b0;
    logic       rst, start, pause, miss_left, miss_right;
    logic       en, serve, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the match.
    int m_phase, m_state, m_delay, m_s1, m_s2, m_dir, m_winner, m_en, m_serve, m_over;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .SERVE_DELAY(SERVE_DELAY),
        .WIN_SCORE  (WIN_SCORE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .en        (en),
        .serve     (serve),
        .serve_dir (serve_dir),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One frame of game rules applied to the model, from the pre-edge view.
    task automatic model_update(input logic r, s, p, ml, mr);
        bit tk;
        if (r) begin
            m_phase = 0; m_state = int'(IDLE); m_delay = 0; m_s1 = 0; m_s2 = 0;
            m_dir = 0; m_winner = 0; m_en = 0; m_serve = 0; m_over = 0;
            return;
        end
        tk      = !p && (m_phase == TICK_DIV - 1);
        m_en    = (tk && m_state == int'(PLAY)) ? 1 : 0;
        m_serve = 0;
        if (!p) m_phase = (m_phase + 1) % TICK_DIV;
        if (m_state == int'(IDLE) || m_state == int'(GAME_OVER)) begin
            if (s) begin
                m_s1 = 0; m_s2 = 0; m_dir = 0;
                m_delay = SERVE_DELAY; m_state = int'(SERVE_WAIT);
            end
        end else if (m_state == int'(SERVE_WAIT)) begin
            if (tk) begin
                m_delay = m_delay - 1;
                if (m_delay == 0) begin
                    m_state = int'(PLAY);
                    m_serve = 1;
                end
            end
        end else if (m_state == int'(PLAY)) begin
            if (ml && mr) m_state = int'(POINT);
            else if (ml) begin
                m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dir = 0; m_state = int'(POINT);
            end else if (mr) begin
                m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dir = 1; m_state = int'(POINT);
            end
        end else begin
            if (m_s1 == WIN_SCORE) begin
                m_state = int'(GAME_OVER); m_winner = 0;
            end else if (m_s2 == WIN_SCORE) begin
                m_state = int'(GAME_OVER); m_winner = 1;
            end else begin
                m_state = int'(SERVE_WAIT); m_delay = SERVE_DELAY;
            end
        end
        m_over = (m_state == int'(GAME_OVER)) ? 1 : 0;
    endtask

    // Apply one cycle of inputs, advance the model, and compare every output.
    task automatic step(input logic r, s, p, ml, mr);
        rst = r; start = s; pause = p; miss_left = ml; miss_right = mr;
        @(posedge clk);
        model_update(r, s, p, ml, mr);
        #1;
        check("state",     32'(state),     m_state);
        check("en",        32'(en),        m_en);
        check("serve",     32'(serve),     m_serve);
        check("serve_dir", 32'(serve_dir), m_dir);
        check("score1",    32'(score1),    m_s1);
        check("score2",    32'(score2),    m_s2);
        check("game_over", 32'(game_over), m_over);
        check("winner",    32'(winner),    m_winner);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Bounded wait until the match is in PLAY; an expired budget shows as a failure.
    task automatic run_until_play(input int budget);
        int n = 0;
        while (m_state != int'(PLAY) && n < budget) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        check("reach_play", 32'(state), int'(PLAY));
    endtask

    int en_seen;

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        model_update(1, 0, 0, 0, 0);

        // Reset then idle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            en_seen += int'(en);
        end
        check("idle_state", 32'(state), int'(IDLE));
        check("idle_no_en", 32'(en_seen), 0);

        // Serve timing and frame enable cadence.
        step(0, 1, 0, 0, 0);
        check("serve_wait", 32'(state), int'(SERVE_WAIT));
        run_until_play(40);
        check("serve_pulse", 32'(serve), 1);
        idle(14);

        // Single miss scores for the other player.
        step(0, 0, 0, 0, 1);
        check("p1_scored", 32'(score1), 1);
        check("dir_right", 32'(serve_dir), 1);
        step(0, 0, 0, 0, 0);
        check("after_point", 32'(state), int'(SERVE_WAIT));
        run_until_play(40);
        idle(3);

        // Simultaneous misses: replayed point.
        step(0, 0, 0, 1, 1);
        check("double_point", 32'(state), int'(POINT));
        step(0, 0, 0, 0, 0);
        check("double_scores", 32'({score1, score2}), 32'({4'd1, 4'd0}));
        run_until_play(40);

        // Player 2 wins, then restart.
        for (int g = 0; g < 3; g++) begin
            run_until_play(40);
            idle(2);
            step(0, 0, 0, 1, 0);
        end
        idle(10);
        check("win_over",   32'(game_over), 1);
        check("win_player", 32'(winner), 1);
        check("win_score2", 32'(score2), 3);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        check("restart", 32'({score1, score2}), 0);
        check("restart_state", 32'(state), int'(SERVE_WAIT));

        // Pause in PLAY freezes enables and the tick phase.
        run_until_play(40);
        idle(2);
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0);
            en_seen += int'(en);
        end
        check("pause_no_en", 32'(en_seen), 0);
        idle(9);

        // Reach score1 = 2, then reset mid-PLAY.
        for (int g = 0; g < 2; g++) begin
            run_until_play(40);
            step(0, 0, 0, 0, 1);
        end
        run_until_play(40);
        idle(2);
        check("pre_rst_score1", 32'(score1), 2);
        step(1, 0, 0, 0, 0);
        check("rst_state", 32'(state), int'(IDLE));
        check("rst_scores", 32'({score1, score2}), 0);
        check("rst_serve", 32'(serve), 0);

        // Randomised play.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
